// File: rtl/ternary_pkg.sv
// Shared balanced-ternary types and constants for the BTISA datapath.
// A trit is two bits: 00 = zero, 01 = +1, 10 = -1 (11 is unused and reads as zero).
package ternary_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t T_ZERO    = 2'b00;
    localparam trit_t T_POS_ONE = 2'b01;
    localparam trit_t T_NEG_ONE = 2'b10;

    localparam int ADDR_TRITS = 9;

    typedef trit_t [ADDR_TRITS-1:0] tword_t;

    // Opcode "--0" in the three most significant trits, rd/rs1/rs2 all zero.
    localparam tword_t BTISA_NOP = {T_NEG_ONE, T_NEG_ONE, T_ZERO, {6{T_ZERO}}};

endpackage

// File: rtl/ternary_inc9.sv
// Balanced-ternary +1 over a 9-trit word, trit 0 least significant.
// The final carry is dropped, so all +1 wraps to all -1.
module ternary_inc9
    import ternary_pkg::*;
(
    input  trit_t [ADDR_TRITS-1:0] i_a,
    output trit_t [ADDR_TRITS-1:0] o_sum
);

    // Ripple carry: +1 plus a carry becomes -1 and carries on; anything else absorbs it.
    always_comb begin : inc_chain
        logic w_carry;
        w_carry = 1'b1;
        o_sum   = '0;
        for (int i = 0; i < ADDR_TRITS; i++) begin
            if (!w_carry) begin
                o_sum[i] = i_a[i];
            end else begin
                case (i_a[i])
                    T_POS_ONE: begin
                        o_sum[i] = T_NEG_ONE;
                        w_carry  = 1'b1;
                    end
                    T_NEG_ONE: begin
                        o_sum[i] = T_ZERO;
                        w_carry  = 1'b0;
                    end
                    default: begin
                        o_sum[i] = T_POS_ONE;
                        w_carry  = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/btisa_fetch.sv
// Instruction fetch for the BTISA core: one outstanding memory request,
// a single-entry skid buffer behind the registered decoder output, branch
// redirect with squash of the in-flight response, and HALT handling.
//
// state  | meaning
// -------+-------------------------------------------------------------
// REQ    | issue imem_req for the current pc this cycle
// WAIT   | request outstanding; r_squash marks its response as dead
// HOLD   | response parked in the skid while the decoder is stalled
// HALTED | HALT seen; no requests until a redirect
module btisa_fetch
    import ternary_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req,
    output trit_t [ADDR_TRITS-1:0]  imem_addr,
    input  logic                    imem_rvalid,
    input  trit_t [ADDR_TRITS-1:0]  imem_rdata,
    input  logic                    stall,
    input  logic                    halt_in,
    input  logic                    redirect_valid,
    input  trit_t [ADDR_TRITS-1:0]  redirect_pc,
    output trit_t [ADDR_TRITS-1:0]  instr_out,
    output trit_t [ADDR_TRITS-1:0]  pc_out,
    output logic                    instr_valid,
    output logic                    halted
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALTED
    } state_t;

    state_t r_state;
    tword_t r_pc;
    logic   r_squash;
    tword_t r_skid_instr;
    tword_t r_skid_pc;
    tword_t r_instr_out;
    tword_t r_pc_out;
    logic   r_instr_valid;

    tword_t w_pc_inc;
    logic   w_out_free;
    logic   w_halt;

    ternary_inc9 u_inc (
        .i_a   (r_pc),
        .o_sum (w_pc_inc)
    );

    assign w_out_free = !r_instr_valid || !stall;
    assign w_halt     = halt_in && r_instr_valid;

    // Held low while in reset so the memory never sees a request from a reset-state FSM.
    assign imem_req    = rst_n && (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign instr_out   = r_instr_out;
    assign pc_out      = r_pc_out;
    assign instr_valid = r_instr_valid;
    assign halted      = (r_state == S_HALTED);

    // Fetch FSM: redirect beats halt, halt beats normal fetch progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_REQ;
            r_pc          <= '0;
            r_squash      <= 1'b0;
            r_skid_instr  <= BTISA_NOP;
            r_skid_pc     <= '0;
            r_instr_out   <= BTISA_NOP;
            r_pc_out      <= '0;
            r_instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            r_pc          <= redirect_pc;
            r_instr_valid <= 1'b0;
            r_instr_out   <= BTISA_NOP;
            case (r_state)
                S_REQ: begin
                    r_squash <= 1'b1;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_squash <= 1'b0;
                        r_state  <= S_REQ;
                    end else begin
                        r_squash <= 1'b1;
                    end
                end
                S_HALTED: begin
                    // A response still owed from before the halt must drain
                    // before a new request goes out.
                    if (r_squash && !imem_rvalid) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_squash <= 1'b0;
                        r_state  <= S_REQ;
                    end
                end
                default: begin
                    r_squash <= 1'b0;
                    r_state  <= S_REQ;
                end
            endcase
        end else if (w_halt) begin
            r_instr_valid <= 1'b0;
            r_instr_out   <= BTISA_NOP;
            r_state       <= S_HALTED;
            case (r_state)
                S_REQ:   r_squash <= 1'b1;
                S_WAIT:  r_squash <= !imem_rvalid;
                default: r_squash <= r_squash;
            endcase
        end else begin
            // Decoder took the current word; later branches overwrite when new data lands.
            if (w_out_free) begin
                r_instr_valid <= 1'b0;
                r_instr_out   <= BTISA_NOP;
            end
            case (r_state)
                S_REQ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_squash) begin
                            r_squash <= 1'b0;
                            r_state  <= S_REQ;
                        end else if (w_out_free) begin
                            r_instr_out   <= imem_rdata;
                            r_pc_out      <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_pc          <= w_pc_inc;
                            r_state       <= S_REQ;
                        end else begin
                            r_skid_instr <= imem_rdata;
                            r_skid_pc    <= r_pc;
                            r_pc         <= w_pc_inc;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_out_free) begin
                        r_instr_out   <= r_skid_instr;
                        r_pc_out      <= r_skid_pc;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_REQ;
                    end
                end
                default: begin
                    if (imem_rvalid && r_squash) begin
                        r_squash <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btisa_fetch.sv
// Directed bench for btisa_fetch: a small instruction memory with selectable
// latency, hand-written sequences for stall/redirect/halt corners, and a table
// of redirect targets checking the ternary pc increment.
module tb_btisa_fetch;
    import ternary_pkg::*;

    logic   clk;
    logic   rst_n;
    logic   imem_req;
    tword_t imem_addr;
    logic   imem_rvalid;
    tword_t imem_rdata;
    logic   stall;
    logic   halt_in;
    logic   redirect_valid;
    tword_t redirect_pc;
    tword_t instr_out;
    tword_t pc_out;
    logic   instr_valid;
    logic   halted;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     mem_lat  = 1;
    int     mem_cnt  = 0;
    tword_t mem_addr_q = '0;

    typedef struct {
        int target;
        int next;
    } vec_t;

    vec_t vecs[10];

    btisa_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .halt_in        (halt_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .instr_valid    (instr_valid),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Integer to 9-trit balanced ternary.
    function automatic tword_t bt(input int v);
        tword_t r;
        int     x;
        int     m;
        r = '0;
        x = v;
        for (int i = 0; i < ADDR_TRITS; i++) begin
            m = ((x % 3) + 3) % 3;
            if (m == 1) begin
                r[i] = T_POS_ONE;
                x    = (x - 1) / 3;
            end else if (m == 2) begin
                r[i] = T_NEG_ONE;
                x    = (x + 1) / 3;
            end else begin
                r[i] = T_ZERO;
                x    = x / 3;
            end
        end
        return r;
    endfunction

    // Memory contents: the address rotated by three trits.
    function automatic tword_t mw(input tword_t a);
        return {a[2:0], a[8:3]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Instruction memory: response mem_lat cycles after each request, one outstanding.
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        if (!rst_n) begin
            mem_cnt = 0;
        end else begin
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mw(mem_addr_q);
                end
            end
            if (imem_req) begin
                n_checks++;
                if (mem_cnt != 0) begin
                    n_fail++;
                    $display("FAIL outstanding: imem_req with %0d cycles of response pending, required 0", mem_cnt);
                end
                mem_cnt    = mem_lat;
                mem_addr_q = imem_addr;
            end
        end
    end

    task automatic set_lat(input int n);
        @(posedge clk);
        #1 mem_lat = n;
        @(negedge clk);
    endtask

    task automatic do_redirect(input int t);
        redirect_pc    = bt(t);
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag, output tword_t a, output bit saw_valid);
        bit found;
        found     = 1'b0;
        saw_valid = 1'b0;
        a         = '0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (instr_valid) saw_valid = 1'b1;
            if (imem_req) begin
                found = 1'b1;
                a     = imem_addr;
            end else begin
                @(negedge clk);
            end
        end
        if (!found) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (instr_valid) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tword_t a;
        bit     sv;

        vecs[0] = '{0, 1};
        vecs[1] = '{1, 2};
        vecs[2] = '{-1, 0};
        vecs[3] = '{9841, -9841};
        vecs[4] = '{-9841, -9840};
        vecs[5] = '{4, 5};
        vecs[6] = '{-5, -4};
        vecs[7] = '{13, 14};
        vecs[8] = '{3280, 3281};
        vecs[9] = '{-3281, -3280};

        rst_n          = 1'b0;
        stall          = 1'b0;
        halt_in        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rdata     = '0;
        imem_rvalid    = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr_out, BTISA_NOP);
        chk("rst_pc", pc_out, 0);
        chk("rst_halted", halted, 0);
        chk("rst_req", imem_req, 0);

        // Straight-line fetch 0, +1, +2
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("n0_req", imem_req, 1);
        chk("n0_addr", imem_addr, bt(0));
        chk("n0_valid", instr_valid, 0);
        @(negedge clk);
        chk("n1_req", imem_req, 0);
        chk("n1_valid", instr_valid, 0);
        @(negedge clk);
        chk("n2_valid", instr_valid, 1);
        chk("n2_pc", pc_out, bt(0));
        chk("n2_instr", instr_out, mw(bt(0)));
        chk("n2_req", imem_req, 1);
        chk("n2_addr", imem_addr, bt(1));
        @(negedge clk);
        chk("n3_valid", instr_valid, 0);
        chk("n3_instr", instr_out, BTISA_NOP);
        @(negedge clk);
        chk("n4_valid", instr_valid, 1);
        chk("n4_pc", pc_out, bt(1));
        chk("n4_instr", instr_out, mw(bt(1)));
        chk("n4_req", imem_req, 1);
        chk("n4_addr", imem_addr, bt(2));

        // Stall for 5 cycles while the response for +2 arrives
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_req", i), imem_req, 0);
            chk($sformatf("stall%0d_valid", i), instr_valid, 1);
            chk($sformatf("stall%0d_pc", i), pc_out, bt(1));
            chk($sformatf("stall%0d_instr", i), instr_out, mw(bt(1)));
        end
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_valid", instr_valid, 1);
        chk("unstall_pc", pc_out, bt(2));
        chk("unstall_instr", instr_out, mw(bt(2)));
        chk("unstall_req", imem_req, 1);
        chk("unstall_addr", imem_addr, bt(3));

        // Redirect to -4 while a slow response is outstanding
        set_lat(3);
        wait_req("c_pre", a, sv);
        chk("c_pre_addr", a, bt(4));
        @(negedge clk);
        do_redirect(-4);
        wait_req("c_redir", a, sv);
        chk("c_redir_addr", a, bt(-4));
        chk("c_old_path_valid", sv, 0);
        wait_valid("c_valid");
        chk("c_pc", pc_out, bt(-4));
        chk("c_instr", instr_out, mw(bt(-4)));

        // Redirect coinciding with rvalid
        set_lat(1);
        wait_req("d_pre", a, sv);
        chk("d_pre_addr", a, bt(-2));
        @(negedge clk);
        do_redirect(20);
        chk("d_valid", instr_valid, 0);
        chk("d_req", imem_req, 1);
        chk("d_addr", imem_addr, bt(20));
        wait_valid("d_wait");
        chk("d_pc", pc_out, bt(20));
        chk("d_instr", instr_out, mw(bt(20)));
        chk("d_next_addr", imem_addr, bt(21));

        // HALT with a request just issued, then restart at +7
        halt_in = 1'b1;
        @(negedge clk);
        halt_in = 1'b0;
        chk("e_halted", halted, 1);
        chk("e_valid", instr_valid, 0);
        sv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (imem_req || !halted) sv = 1'b1;
            @(negedge clk);
        end
        chk("e_quiet", sv, 0);
        do_redirect(7);
        chk("e_restart_halted", halted, 0);
        chk("e_restart_req", imem_req, 1);
        chk("e_restart_addr", imem_addr, bt(7));
        wait_valid("e_wait");
        chk("e_pc", pc_out, bt(7));

        // Redirect and halt together: redirect wins
        halt_in = 1'b1;
        do_redirect(-10);
        halt_in = 1'b0;
        chk("f_halted", halted, 0);
        wait_req("f_req", a, sv);
        chk("f_addr", a, bt(-10));
        chk("f_halted_late", halted, 0);

        // Redirect targets and the following fetch address
        for (int k = 0; k < 10; k++) begin
            do_redirect(vecs[k].target);
            wait_req($sformatf("v%0d_req", k), a, sv);
            chk($sformatf("v%0d_addr", k), a, bt(vecs[k].target));
            chk($sformatf("v%0d_stale", k), sv, 0);
            wait_valid($sformatf("v%0d_wait", k));
            chk($sformatf("v%0d_pc", k), pc_out, bt(vecs[k].target));
            chk($sformatf("v%0d_instr", k), instr_out, mw(bt(vecs[k].target)));
            wait_req($sformatf("v%0d_nreq", k), a, sv);
            chk($sformatf("v%0d_next", k), a, bt(vecs[k].next));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btisa_fetch.md
BTISA_FETCH -- requirements
Module: btisa_fetch

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 imem_req  out  1  one-cycle request pulse to instruction memory.
REQ-004 imem_addr  out  trit_t[8:0]  fetch address, valid when imem_req=1.
REQ-005 imem_rvalid  in  1  response strobe, >=1 cycle after imem_req; at most one outstanding.
REQ-006 imem_rdata  in  trit_t[8:0]  instruction word, valid with imem_rvalid.
REQ-007 stall  in  1  downstream does not consume instr_out this cycle.
REQ-008 halt_in  in  1  decoder flagged instr_out as HALT; qualified by instr_valid.
REQ-009 redirect_valid  in  1  one-cycle branch/jump redirect.
REQ-010 redirect_pc  in  trit_t[8:0]  redirect target.
REQ-011 instr_out  out  trit_t[8:0]  registered instruction to decoder.
REQ-012 pc_out  out  trit_t[8:0]  address of instr_out.
REQ-013 instr_valid  out  1  instr_out holds a live instruction.
REQ-014 halted  out  1  fetch stopped by HALT.

Function
REQ-015 States: REQ (issue), WAIT (outstanding), HOLD (skid full), HALTED.
REQ-016 REQ: imem_req=1, imem_addr=pc; next WAIT.
REQ-017 imem_req SHALL be 0 in every other state.
REQ-018 WAIT, rvalid, squash=0, output free: capture word and pc into instr_out/pc_out; instr_valid=1; pc<=pc+1; next REQ.
REQ-019 Output free means instr_valid=0 or stall=0.
REQ-020 WAIT, rvalid, squash=0, output blocked: capture into skid; pc<=pc+1; next HOLD.
REQ-021 HOLD: on output free, move skid to output; next REQ.
REQ-022 Output consumed with no new data: instr_valid<=0 and instr_out<=BTISA_NOP.
REQ-023 redirect_valid in any state, at that edge: pc<=redirect_pc; instr_valid<=0; skid dropped.
REQ-024 Redirect in WAIT with no rvalid that cycle: squash<=1; stay WAIT.
REQ-025 Redirect in REQ: squash<=1; next WAIT.
REQ-026 Redirect in WAIT coinciding with rvalid: word discarded; next REQ.
REQ-027 Redirect in HOLD or HALTED: next REQ; halted<=0.
REQ-028 Squashed rvalid: word discarded; squash<=0; next REQ, or stay HALTED if halted.
REQ-029 halt_in with instr_valid=1 and no redirect: next HALTED; instr_valid<=0; skid dropped.
REQ-030 Halt while a request is outstanding: squash<=1.
REQ-031 redirect_valid and halt_in in the same cycle: redirect wins; halt ignored.
REQ-032 pc+1 is balanced-ternary increment over 9 trits, LSB trit 0.
REQ-033 Increment wraps all-T_POS_ONE (+9841) to all-T_NEG_ONE (-9841).
REQ-034 stall SHALL never alter pc, issue requests, or drop data.

Reset
REQ-035 rst_n=0 at edge: state=REQ, pc=all T_ZERO, squash=0, skid empty.
REQ-036 Reset outputs: instr_valid=0, instr_out=BTISA_NOP, pc_out=all T_ZERO, halted=0, imem_req=0.
REQ-037 Reset mid-transaction abandons the outstanding response; memory SHALL be reset concurrently.
REQ-038 First cycle after release: imem_req=1 with imem_addr=0.

Structure
REQ-039 ternary_pkg SHALL gain BTISA_NOP (--0 opcode, rd/rs1/rs2 all T_ZERO) and ADDR_TRITS=9.
REQ-040 The state enum is local to the module.
REQ-041 One combinational sub-module, ternary_inc9, SHALL implement the 9-trit increment with carry chain.
REQ-042 Only the output, skid, pc, squash and state are registered.

Verification
REQ-043 Reset release, rvalid 1 cycle after each req, stall=0: addresses 0,+1,+2; instr_valid on the edge after each rvalid.
REQ-044 Stall held 5 cycles while a response arrives: instr_out unchanged, skid fills, no imem_req; after stall drops, skid word is next and addr continues.
REQ-045 Redirect to -4 during WAIT: next rvalid discarded; next imem_addr=-4; no instruction from old path becomes valid.
REQ-046 Redirect with rvalid in the same cycle: word dropped; imem_addr=redirect_pc in the following REQ.
REQ-047 halt_in with instr_valid=1: halted=1, no further imem_req; later redirect to +7 restarts at +7 with halted=0.
REQ-048 pc=+9841: next imem_addr=-9841; pc=+1 (0,0,...,0,+) increments to +2 (...,+,-).
